// File: rtl/tab_hash_pkg.sv
// Shared definitions for the tabulation hash engine: default geometry constants
// and the engine state encoding.
package tab_hash_pkg;

  localparam int unsigned KEY_BYTES = 4;    // 8-bit key chunks per key
  localparam int unsigned DBITS     = 32;   // table word / hash width
  localparam int unsigned TBL_AW    = 9;    // table address width
  localparam int unsigned TBL_NLOC  = 259;  // table words, addresses 0..258

  typedef enum logic [1:0] {
    StIdle,
    StHash,
    StDone
  } state_e;

endpackage

// File: rtl/tab_hash_engine.sv
// Tabulation hash engine. Hashes one key byte per cycle against an external
// four-read static table: hash = XOR_i T[byte_i + (i mod 4)].
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   key handshake; in_key byte i is bits [8i+7:8i]
//   out_valid/out_ready hash handshake; out_hash held stable while waiting
//   tbl_addr            table read address (0 outside HASH)
//   tbl_d0..tbl_d3      table words T[a], T[a+1], T[a+2], T[a+3], a = tbl_addr
module tab_hash_engine #(
  parameter int unsigned KEY_BYTES = tab_hash_pkg::KEY_BYTES,
  parameter int unsigned DBITS     = tab_hash_pkg::DBITS,
  parameter int unsigned TBL_AW    = tab_hash_pkg::TBL_AW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [KEY_BYTES*8-1:0] in_key,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DBITS-1:0]       out_hash,
  output logic [TBL_AW-1:0]      tbl_addr,
  input  logic [DBITS-1:0]       tbl_d0,
  input  logic [DBITS-1:0]       tbl_d1,
  input  logic [DBITS-1:0]       tbl_d2,
  input  logic [DBITS-1:0]       tbl_d3
);

  import tab_hash_pkg::*;

  localparam int unsigned IdxW = $clog2(KEY_BYTES) + 1;

  state_e                 state_q;
  logic [KEY_BYTES*8-1:0] key_q;
  logic [IdxW-1:0]        idx_q;
  logic [DBITS-1:0]       acc_q;
  logic [DBITS-1:0]       out_hash_q;
  logic                   out_valid_q;
  logic                   in_ready_q;

  logic [7:0]             cur_byte;
  logic [1:0]             lane_sel;
  logic [DBITS-1:0]       lane_word;
  logic [DBITS-1:0]       acc_d;
  logic                   last_byte;

  // Byte selected by the running index; driven purely from registers.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (idx_q == IdxW'(i)) cur_byte = key_q[8*i +: 8];
    end
  end

  // Byte i reads T[byte_i + (i mod 4)], i.e. lane (i mod 4) of the table port.
  always_comb begin
    lane_sel  = 2'(int'(idx_q) % 4);
    lane_word = tbl_d0;
    case (lane_sel)
      2'd0:    lane_word = tbl_d0;
      2'd1:    lane_word = tbl_d1;
      2'd2:    lane_word = tbl_d2;
      default: lane_word = tbl_d3;
    endcase
  end

  assign acc_d     = acc_q ^ lane_word;
  assign last_byte = (idx_q == IdxW'(KEY_BYTES - 1));
  assign tbl_addr  = (state_q == StHash) ? TBL_AW'(cur_byte) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_hash_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            key_q      <= in_key;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StHash;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StHash: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (last_byte) begin
            out_hash_q  <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_hash  = out_hash_q;

endmodule

// File: tb/tb_tab_hash_engine.sv
// Self-checking bench for tab_hash_engine with a table model T[j] = j.
module tb_tab_hash_engine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hash;
  logic [8:0]  tbl_addr;
  logic [31:0] tbl_d0, tbl_d1, tbl_d2, tbl_d3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  tab_hash_engine #(
    .KEY_BYTES(4),
    .DBITS    (32),
    .TBL_AW   (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_key   (in_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hash (out_hash),
    .tbl_addr (tbl_addr),
    .tbl_d0   (tbl_d0),
    .tbl_d1   (tbl_d1),
    .tbl_d2   (tbl_d2),
    .tbl_d3   (tbl_d3)
  );

  // Table model: T[j] = j, four consecutive words from tbl_addr.
  assign tbl_d0 = {23'd0, tbl_addr};
  assign tbl_d1 = {23'd0, tbl_addr} + 32'd1;
  assign tbl_d2 = {23'd0, tbl_addr} + 32'd2;
  assign tbl_d3 = {23'd0, tbl_addr} + 32'd3;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Drive a key (called at a negedge); returns at the negedge after acceptance.
  task automatic accept_key(input logic [31:0] key, output bit ok, output int at_cyc);
    int n = 0;
    in_valid = 1'b1;
    in_key   = key;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    at_cyc = cyc;
  endtask

  task automatic wait_valid(output bit seen, output int at_cyc);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    seen   = out_valid;
    at_cyc = cyc;
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_key = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_hash !== 32'd0) begin errors++;
      $display("FAIL reset_out_hash: got %h expected 00000000", out_hash); end
    checks++; if (tbl_addr !== 9'd0) begin errors++;
      $display("FAIL reset_tbl_addr: got %h expected 000", tbl_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    bit ok, seen; int c0, c1; logic [31:0] e;
    out_ready = 1'b1;
    accept_key(32'h0000_00FF, ok, c0);
    exp_q.push_back(32'h0000_00FF);
    in_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: got 0 expected 1"); end
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL single_busy_in_ready: got %b expected 0", in_ready); end
    wait_valid(seen, c1);
    e = pop_exp();
    checks++; if (!seen || (c1 - c0) != 4) begin errors++;
      $display("FAIL single_latency: got %0d expected 4", c1 - c0); end
    checks++; if (out_hash !== e) begin errors++;
      $display("FAIL single_hash: got %h expected %h", out_hash, e); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || tbl_addr !== 9'd0) begin
      errors++;
      $display("FAIL single_back_idle: got v=%b r=%b a=%h expected v=0 r=1 a=000",
               out_valid, in_ready, tbl_addr);
    end
  endtask

  task automatic test_all_ones();
    bit ok, seen; int c0, c1; logic [31:0] e;
    out_ready = 1'b1;
    accept_key(32'hFFFF_FFFF, ok, c0);
    exp_q.push_back(32'h0000_01FC);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (tbl_addr !== 9'h0FF) begin errors++;
        $display("FAIL ones_tbl_addr[%0d]: got %h expected 0ff", k, tbl_addr); end
      if (k < 3) @(negedge clk);
    end
    wait_valid(seen, c1);
    e = pop_exp();
    checks++; if (!seen || out_hash !== e) begin errors++;
      $display("FAIL ones_hash: got %h expected %h", out_hash, e); end
    checks++; if (tbl_addr !== 9'd0) begin errors++;
      $display("FAIL ones_done_tbl_addr: got %h expected 000", tbl_addr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok, seen; int c0, c1; int bad = 0; logic [31:0] e;
    out_ready = 1'b0;
    accept_key(32'h0302_0100, ok, c0);
    exp_q.push_back(32'h0000_0000);
    in_valid = 1'b0;
    wait_valid(seen, c1);
    e = pop_exp();
    checks++; if (!seen || out_hash !== e) begin errors++;
      $display("FAIL bp_hash: got %h expected %h", out_hash, e); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_hash !== e || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    bit ok0, ok1, seen; int c0, c1, cv; logic [31:0] e;
    out_ready = 1'b1;
    accept_key(32'h0000_00FF, ok0, c0);
    exp_q.push_back(32'h0000_00FF);
    in_key = 32'hFFFF_FFFF;
    wait_valid(seen, cv);
    e = pop_exp();
    checks++; if (!seen || out_hash !== e) begin errors++;
      $display("FAIL b2b_hash0: got %h expected %h", out_hash, e); end
    accept_key(32'hFFFF_FFFF, ok1, c1);
    exp_q.push_back(32'h0000_01FC);
    in_valid = 1'b0;
    checks++; if (!ok0 || !ok1 || (c1 - c0) != 6) begin errors++;
      $display("FAIL b2b_spacing: got %0d expected 6", c1 - c0); end
    wait_valid(seen, cv);
    e = pop_exp();
    checks++; if (!seen || out_hash !== e) begin errors++;
      $display("FAIL b2b_hash1: got %h expected %h", out_hash, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hash();
    bit ok, seen; bit rose = 0; int c0, c1; logic [31:0] e;
    out_ready = 1'b1;
    accept_key(32'h0000_00FF, ok, c0);
    exp_q.push_back(32'h0000_00FF);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());  // aborted hash is discarded
    checks++; if (out_valid !== 1'b0 || tbl_addr !== 9'd0) begin errors++;
      $display("FAIL abort_state: got v=%b a=%h expected v=0 a=000", out_valid, tbl_addr); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose = 1;
    end
    checks++; if (rose) begin errors++;
      $display("FAIL abort_no_valid: got 1 expected 0"); end
    accept_key(32'h0000_00FF, ok, c0);
    exp_q.push_back(32'h0000_00FF);
    in_valid = 1'b0;
    wait_valid(seen, c1);
    e = pop_exp();
    checks++; if (!ok || !seen || (c1 - c0) != 4 || out_hash !== e) begin errors++;
      $display("FAIL abort_next_key: got lat=%0d h=%h expected lat=4 h=%h",
               c1 - c0, out_hash, e);
    end
    @(negedge clk);
  endtask

  task automatic test_key_change();
    bit ok, seen; int c0, c1; logic [31:0] e;
    out_ready = 1'b1;
    accept_key(32'hFFFF_FFFF, ok, c0);
    exp_q.push_back(32'h0000_01FC);
    in_key   = 32'h0000_0000;
    in_valid = 1'b0;
    wait_valid(seen, c1);
    e = pop_exp();
    checks++; if (!ok || !seen || out_hash !== e) begin errors++;
      $display("FAIL key_change_hash: got %h expected %h", out_hash, e); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ones();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_hash();
    test_key_change();
    checks++; if (exp_q.size() != 0) begin errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
